// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: request/response controller for an 8-entry byte-cell array.
// Drives one-hot cell select and dual-rail data; captures the shared read bus.
module mem8x8_ctrl #(
  parameter int unsigned READ_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [7:0] cell_sel,
  output logic       cell_op,
  output logic [7:0] cell_inp,
  output logic [7:0] cell_inpn,
  input  logic [7:0] cell_bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(READ_WAIT - 1);

  state_t     state;
  logic [2:0] cnt;

  // Complement rail is always the exact inverse of the true rail.
  assign cell_inpn = ~cell_inp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      cell_sel  <= 8'h00;
      cell_op   <= 1'b1;
      cell_inp  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cell_sel  <= 8'b1 << req_addr;
            cell_op   <= ~req_we;
            cell_inp  <= req_we ? req_wdata : 8'h00;
            if (req_we) begin
              state <= WRITE;
            end else begin
              state <= READ;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          cell_sel  <= 8'h00;
          cell_op   <= 1'b1;
          cell_inp  <= 8'h00;
        end
        READ: begin
          if (cnt == 3'd0) begin
            state     <= RESP;
            rsp_rdata <= cell_bus;
            rsp_valid <= 1'b1;
            cell_sel  <= 8'h00;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem8x8_ctrl.md
MEM8X8_CTRL -- requirements
Module: mem8x8_ctrl

Interface
REQ-001 Parameter: READ_WAIT, default 2, number of cycles a read drives the selected byte cell before capture; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  3  byte address 0..7.
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  read data available.
REQ-010 rsp_ready  input  1  consumer takes read data.
REQ-011 rsp_rdata  output  8  registered read data.
REQ-012 cell_sel  output  8  one-hot byte-cell select, bit i = address i.
REQ-013 cell_op  output  1  byte-cell operation: 0 = write, 1 = read.
REQ-014 cell_inp  output  8  true data to byte cells.
REQ-015 cell_inpn  output  8  complement data to byte cells.
REQ-016 cell_bus  input  8  shared tri-state read bus from the byte cells.

Function
REQ-017 FSM states: IDLE, WRITE, READ, RESP; encoding free; all outputs registered or decoded from state/registers only, with no combinational path from any input to any output.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-019 Address, data and we SHALL be latched at acceptance; later input changes have no effect on the operation.
REQ-020 IDLE outputs: cell_sel=0x00, cell_op=1, cell_inp=0x00, cell_inpn=0xFF.
REQ-021 Write accepted at edge ending cycle N -> WRITE during cycle N+1 exactly one cycle: cell_sel=one-hot(addr), cell_op=0, cell_inp=wdata, cell_inpn=~wdata; IDLE (req_ready=1) in cycle N+2.
REQ-022 Writes produce no response; rsp_valid and rsp_rdata unaffected by writes.
REQ-023 Read accepted at edge ending cycle N -> READ during cycles N+1..N+READ_WAIT: cell_sel=one-hot(addr), cell_op=1, cell_inp=0x00, cell_inpn=0xFF; down-counter tracks cycles.
REQ-024 cell_bus SHALL be captured into rsp_rdata on the edge ending cycle N+READ_WAIT; RESP entered with rsp_valid=1 from cycle N+READ_WAIT+1.
REQ-025 RESP: cell_sel=0x00, cell_op=1; rsp_valid held 1 and rsp_rdata stable until an edge with rsp_ready=1; then IDLE next cycle, rsp_valid=0.
REQ-026 rsp_ready=1 on the first RESP cycle completes the handshake in that cycle (one-cycle rsp_valid pulse).
REQ-027 No request accepted in WRITE, READ or RESP; req_valid held high is accepted in the first following IDLE cycle.
REQ-028 rsp_rdata retains its last captured value in all states other than the capture edge.
REQ-029 Invariants: cell_inpn == ~cell_inp always; at most one cell_sel bit set; cell_op=0 only in WRITE.
REQ-030 Back-to-back throughput: write every 2 cycles; read every READ_WAIT+2 cycles when rsp_ready tied 1.

Reset
REQ-031 rst=1 SHALL immediately (without clock) force IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0x00, cell_sel=0x00, cell_op=1, cell_inp=0x00, cell_inpn=0xFF.
REQ-032 Reset during WRITE or READ aborts the operation; no response is produced for it.
REQ-033 After rst deasserts, first request may be accepted on the first rising edge.

Verification
REQ-034 Write addr 5 data 0xAA -> one cycle later cell_sel=0x20, cell_op=0, cell_inp=0xAA, cell_inpn=0x55 for exactly one cycle; rsp_valid stays 0.
REQ-035 Read addr 2, cell_bus driven 0xCC, READ_WAIT=2, rsp_ready=1 -> cell_sel=0x04, cell_op=1 for two cycles; rsp_valid=1, rsp_rdata=0xCC on third cycle after acceptance for one cycle.
REQ-036 Read addr 7 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata=bus value held, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-037 req_valid held high with alternating write 0xF0 addr 0 / read addr 0 -> writes every 2 cycles, reads every 4 cycles; invariants of REQ-029 hold every cycle.
REQ-038 rst asserted mid-READ (between clock edges) -> all outputs at reset values before next edge; rsp_rdata=0x00, no rsp_valid pulse afterwards.
REQ-039 READ_WAIT=1 and READ_WAIT=7 builds -> capture edge and rsp_valid timing match REQ-024.
